stream_register_pipe: RTL

//   Parametrised multi-stage register slice on a ready/valid stream. It generalises the

---
 rtl/stream_register_pipe.sv | 92 +++++++++
 1 files changed

// File: rtl/stream_register_pipe.sv
// Multi-stage ready/valid register slice with selectable ready pass-through,
// synchronous clear and an occupancy count.
module stream_register_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter bit READY_PASS = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

  localparam int UW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      v_q;
  logic [DATA_WIDTH-1:0] d_q  [DEPTH];
  logic [DATA_WIDTH-1:0] d_in [DEPTH];
  logic [DEPTH:0]        rdy_chain;
  logic [DEPTH:0]        vld_chain;
  logic [DEPTH-1:0]      load;
  logic [DEPTH-1:0]      drain;

  // Index k of each chain is what stage k sees; the extra top bit of
  // rdy_chain is the downstream ready, the bottom bit of vld_chain is valid_i.
  assign vld_chain = {v_q, valid_i};

  always_comb begin
    rdy_chain        = '0;
    rdy_chain[DEPTH] = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_chain[k] = ~v_q[k] | (READY_PASS & rdy_chain[k+1]);
    end
  end

  always_comb begin
    load  = '0;
    drain = '0;
    for (int k = 0; k < DEPTH; k++) begin
      load[k]  = vld_chain[k] & rdy_chain[k];
      drain[k] = v_q[k] & rdy_chain[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_din
    if (k == 0) begin : g_first
      assign d_in[k] = data_i;
    end else begin : g_next
      assign d_in[k] = d_q[k-1];
    end
  end

  // A load always wins over a drain of the same stage, so a full stage that
  // is passing its beat on and taking a new one stays valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else if (clr_i) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          v_q[k] <= 1'b1;
          d_q[k] <= d_in[k];
        end else if (drain[k]) begin
          v_q[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    usage_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      usage_o = usage_o + UW'(v_q[k]);
    end
  end

  assign ready_o = rdy_chain[0] & ~clr_i;
  assign valid_o = v_q[DEPTH-1] & ~clr_i;
  assign data_o  = d_q[DEPTH-1];

endmodule
